nios_system_cpu_0_ocimem_ctrl: RTL and testbench
================================================

// Module: nios_system_cpu_0_ocimem_ctrl
// PURPOSE
//  Debug on-chip memory (OCI RAM) controller, clk domain, directly downstream of the JTAG debug wrapper.
//  Consumes jdo / take_action_ocimem_* strobes; returns MonDReg, monitor_ready and monitor_error to the wrapper.
//  Arbitrates one single-port RAM between JTAG host accesses and a CPU Avalon-MM slave port.
// PARAMETERS
//  AW     8   RAM word-address width, 1..15; DEPTH = 2**AW 32-bit words
//  INIT_WP 0  reset value of the CPU write-protect flag (used only with OCIMEM_CPU_WP_EN)
// PORTS
//  clk                     in   1   system clock; sole clock
//  reset                   in   1   synchronous, active-high reset
//  jdo                     in   38  JTAG data-out word, valid while a take_* strobe is high
//  take_action_ocimem_a    in   1   control/address strobe (1 cycle)
//  take_no_action_ocimem_a in   1   streaming-read strobe (1 cycle)
//  take_action_ocimem_b    in   1   streaming-write strobe (1 cycle)
//  MonDReg                 out  32  last JTAG read data
//  monitor_ready           out  1   last JTAG op complete
//  monitor_error           out  1   sticky: JTAG request overrun
//  cpu_address             in   AW  CPU word address
//  cpu_read / cpu_write    in   1   CPU read / write request
//  cpu_writedata           in   32  CPU write data
//  cpu_byteenable          in   4   CPU byte lanes
//  cpu_readdata            out  32  CPU read data, valid while cpu_read & !cpu_waitrequest
//  cpu_waitrequest         out  1   Avalon stall
// BEHAVIOUR
//  - Reset: MonDReg=0, monitor_ready=1, monitor_error=0, cpu_readdata=0, jaddr=0, pending flags=0, wp=INIT_WP, state=IDLE.
//    RAM contents are not reset. Reset mid-op aborts the op; the RAM write in that cycle is suppressed.
//  - take_action_ocimem_a:
//    jdo[35]=1 loads jaddr<=jdo[17+AW-1:17]. jdo[34]=1 queues a read at the new jaddr.
//    jdo[33]=1 clears monitor_error. jdo[32] is the wp value.
//  - take_no_action_ocimem_a: queues a read at jaddr.
//  - take_action_ocimem_b: queues a write of jdo[34:3] to jaddr.
//  - Any queue: set jrd_pend or jwr_pend (wdata latched); monitor_ready<=0 next cycle.
//  - Overrun: a new queue while a pend is set means the new request replaces the old one and monitor_error<=1.
//    If clear and overrun coincide, set wins.
//  - FSM IDLE/J_RD/J_CAP/J_WR/C_RD/C_RDV. In IDLE, a JTAG pend has priority over the CPU.
//    IDLE->J_RD (RAM addr=jaddr) ->J_CAP: MonDReg<=q, jaddr++, monitor_ready<=1, ->IDLE. Read latency 3 clk from strobe.
//    IDLE->J_WR: mem[jaddr]<=wdata (all bytes), jaddr++, monitor_ready<=1, ->IDLE.
//    IDLE & cpu_read & !pend ->C_RD ->C_RDV: cpu_readdata<=q, waitrequest low 1 cycle, ->IDLE.
//    IDLE & cpu_write & !pend: byte-enabled write the same cycle; waitrequest low combinationally.
//  - cpu_waitrequest = !((state==C_RDV) | (state==IDLE & cpu_write & !cpu_read & !jrd_pend & !jwr_pend)).
//    cpu_read & cpu_write together are treated as a read.
//  - jaddr wraps DEPTH-1 -> 0. No other address checks; all AW bits are decoded.
//  - A strobe arriving in the same cycle its predecessor's pend is cleared is a fresh queue, not an overrun.
// CONFIGURATION
//  OCIMEM_CPU_WP_EN defined:
//    take_action_ocimem_a loads wp<=jdo[32]. While wp=1, CPU writes complete with normal timing and leave the RAM unchanged.
//  OCIMEM_CPU_WP_EN undefined: no wp register; jdo[32] is ignored; CPU writes always land.
// TESTING
//  1 ocimem_a jdo[35]=1,jdo[34]=1,addr=0x05 with mem[5]=0xDEADBEEF -> MonDReg=0xDEADBEEF, ready 0->1 within 3 clk, jaddr=6.
//  2 ocimem_b x3 data 1,2,3 at jaddr=DEPTH-1 -> mem[DEPTH-1]=1, mem[0]=2, mem[1]=3 (wrap).
//  3 CPU write 0xA5A5A5A5 be=4'b0011 at 0x10 over 0xFFFFFFFF, then read -> 0xFFFFA5A5; read waitrequest high exactly 2 clk.
//  4 Two take_no_action_ocimem_a strobes 1 clk apart -> monitor_error=1, one read done; ocimem_a jdo[33]=1 -> error 0.
//  5 JTAG write pend and cpu_read in the same cycle -> JTAG write first, CPU stalls extra cycle(s), gets post-write data.
//  6 OCIMEM_CPU_WP_EN: wp=1, CPU write 0x1234 to 0x20 -> waitrequest low, mem[0x20] unchanged; undefined -> mem[0x20]=0x1234.

Source files
------------

// File: rtl/nios_system_cpu_0_ocimem_ctrl.sv
// ----------------------------------------------------------------------------
// nios_system_cpu_0_ocimem_ctrl
//
// Purpose
//   Debug on-chip memory (OCI RAM) controller in the clk domain. It sits
//   directly downstream of the JTAG debug wrapper and shares one single-port
//   RAM of DEPTH = 2**AW 32-bit words between JTAG host accesses and a CPU
//   Avalon-MM slave port.
//
// Parameters
//   AW       RAM word-address width (1..15)
//   INIT_WP  reset value of the CPU write-protect flag
//
// Ports
//   clk, reset                   sole clock; synchronous active-high reset
//   jdo[37:0]                    JTAG data-out word, valid with a take_* strobe
//   take_action_ocimem_a         control/address strobe (jdo[35] load addr,
//                                jdo[34] read, jdo[33] clear error, jdo[32] wp)
//   take_no_action_ocimem_a      streaming read at jaddr
//   take_action_ocimem_b         streaming write of jdo[34:3] at jaddr
//   MonDReg[31:0]                last JTAG read data
//   monitor_ready                last JTAG op complete
//   monitor_error                sticky JTAG request overrun
//   cpu_address/read/write/writedata/byteenable   Avalon-MM slave inputs
//   cpu_readdata, cpu_waitrequest                 Avalon-MM slave outputs
//
// Configuration
//   OCIMEM_CPU_WP_EN  when defined, take_action_ocimem_a loads a write-protect
//                     flag from jdo[32]; while set, CPU writes complete with
//                     normal timing but leave the RAM unchanged.
//
// Handshake: the CPU side is Avalon-MM. A read completes in the single cycle
// where cpu_read is high and cpu_waitrequest is low; cpu_readdata is valid in
// that cycle. A write is accepted in any cycle where cpu_write is high and
// cpu_waitrequest is low. Requests must be held stable while stalled.
// ----------------------------------------------------------------------------
module nios_system_cpu_0_ocimem_ctrl #(
    parameter int AW      = 8,
    parameter bit INIT_WP = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_no_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error,
    input  logic [AW-1:0] cpu_address,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [31:0]   cpu_writedata,
    input  logic [3:0]    cpu_byteenable,
    output logic [31:0]   cpu_readdata,
    output logic          cpu_waitrequest
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, C_RD, C_RDV} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] jaddr_q, jaddr_d;
    logic          jrd_pend_q, jrd_pend_d;
    logic          jwr_pend_q, jwr_pend_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   mondreg_q, mondreg_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic [31:0]   rd_q;
    logic          cpu_wp;

    logic [31:0]   mem [DEPTH];

    // RAM port signals
    logic [AW-1:0] ram_addr;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    logic q_rd, q_wr, queue, overrun, cpu_wr_ok;

    wire unused_ok = ^{jdo[37:36], jdo[2:0], INIT_WP};

    assign q_wr  = take_action_ocimem_b;
    assign q_rd  = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[34]);
    assign queue = q_wr | q_rd;

    // A pend is released in the cycle its op completes; a strobe landing in
    // that same cycle is therefore a fresh request, not an overrun.
    assign overrun = queue & ((jrd_pend_q & (state_q != J_CAP)) |
                              (jwr_pend_q & (state_q != J_WR)));

    assign cpu_wr_ok = (state_q == IDLE) & cpu_write & ~cpu_read &
                       ~jrd_pend_q & ~jwr_pend_q;

    assign cpu_waitrequest = ~((state_q == C_RDV) | cpu_wr_ok);
    assign cpu_readdata    = rd_q;
    assign MonDReg         = mondreg_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;

`ifdef OCIMEM_CPU_WP_EN
    logic wp_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= INIT_WP;
        end else if (take_action_ocimem_a) begin
            wp_q <= jdo[32];
        end
    end
    assign cpu_wp = wp_q;
`else
    assign cpu_wp = 1'b0;
`endif

    // Next state and JTAG bookkeeping
    always_comb begin
        state_d    = state_q;
        jaddr_d    = jaddr_q;
        jrd_pend_d = jrd_pend_q;
        jwr_pend_d = jwr_pend_q;
        wdata_d    = wdata_q;
        mondreg_d  = mondreg_q;
        ready_d    = ready_q;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                // JTAG pend has priority over the CPU
                if (jwr_pend_q)      state_d = J_WR;
                else if (jrd_pend_q) state_d = J_RD;
                else if (cpu_read)   state_d = C_RD;
            end
            J_RD:  state_d = J_CAP;
            J_CAP: begin
                mondreg_d  = rd_q;
                jaddr_d    = jaddr_q + AW'(1);
                ready_d    = 1'b1;
                jrd_pend_d = 1'b0;
                state_d    = IDLE;
            end
            J_WR: begin
                jaddr_d    = jaddr_q + AW'(1);
                ready_d    = 1'b1;
                jwr_pend_d = 1'b0;
                state_d    = IDLE;
            end
            C_RD:    state_d = C_RDV;
            C_RDV:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // An address load overrides the post-access increment
        if (take_action_ocimem_a & jdo[35]) jaddr_d = jdo[17 +: AW];

        // A new request replaces whatever is pending
        if (q_wr) begin
            jwr_pend_d = 1'b1;
            jrd_pend_d = 1'b0;
            wdata_d    = jdo[34:3];
        end else if (q_rd) begin
            jrd_pend_d = 1'b1;
            jwr_pend_d = 1'b0;
        end
        if (queue) ready_d = 1'b0;

        // Set beats clear when they coincide
        if (take_action_ocimem_a & jdo[33]) error_d = 1'b0;
        if (overrun)                        error_d = 1'b1;
    end

    // RAM port muxing; writes are suppressed while reset is asserted
    always_comb begin
        ram_addr = (state_q == J_RD) ? jaddr_q : cpu_address;
        rd_en    = (state_q == J_RD) | (state_q == C_RD);
        wr_addr  = cpu_address;
        wr_data  = cpu_writedata;
        wr_be    = 4'b0000;
        if (!reset) begin
            if (state_q == J_WR) begin
                wr_addr = jaddr_q;
                wr_data = wdata_q;
                wr_be   = 4'b1111;
            end else if (cpu_wr_ok & ~cpu_wp) begin
                wr_be   = cpu_byteenable;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= 32'h0;
        end else if (rd_en) begin
            rd_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            jaddr_q    <= '0;
            jrd_pend_q <= 1'b0;
            jwr_pend_q <= 1'b0;
            wdata_q    <= 32'h0;
            mondreg_q  <= 32'h0;
            ready_q    <= 1'b1;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            jaddr_q    <= jaddr_d;
            jrd_pend_q <= jrd_pend_d;
            jwr_pend_q <= jwr_pend_d;
            wdata_q    <= wdata_d;
            mondreg_q  <= mondreg_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_nios_system_cpu_0_ocimem_ctrl.sv
module tb_nios_system_cpu_0_ocimem_ctrl;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [37:0]   jdo = '0;
    logic          take_action_ocimem_a = 1'b0;
    logic          take_no_action_ocimem_a = 1'b0;
    logic          take_action_ocimem_b = 1'b0;
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;
    logic [AW-1:0] cpu_address = '0;
    logic          cpu_read = 1'b0;
    logic          cpu_write = 1'b0;
    logic [31:0]   cpu_writedata = '0;
    logic [3:0]    cpu_byteenable = '0;
    logic [31:0]   cpu_readdata;
    logic          cpu_waitrequest;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nios_system_cpu_0_ocimem_ctrl #(.AW(AW), .INIT_WP(1'b0)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic ld, input logic rd, input logic clr,
                                          input logic wp, input logic [AW-1:0] a);
        logic [37:0] v;
        v = '0;
        v[35] = ld;
        v[34] = rd;
        v[33] = clr;
        v[32] = wp;
        v[17 +: AW] = a;
        return v;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    // kind: 0 = ocimem_a, 1 = no_action_ocimem_a, 2 = ocimem_b
    task automatic jstrobe(input int kind, input logic [37:0] val);
        jdo = val;
        take_action_ocimem_a    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_b    = (kind == 2);
        step();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    // Counts cycles after the strobe edge until monitor_ready returns
    task automatic wait_ready(output int cyc, output logic r0);
        cyc = 0;
        @(negedge clk);
        r0 = monitor_ready;
        while (!monitor_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20) chk("ready_timeout", 32'(cyc), 32'd0);
        step();
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int waits);
        cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_write = 1'b1;
        waits = 0;
        @(negedge clk);
        while (cpu_waitrequest && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) chk("cpu_wr_timeout", 32'(waits), 32'd0);
        step();
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a, output logic [31:0] d, output int waits);
        cpu_address = a; cpu_read = 1'b1;
        waits = 0;
        @(negedge clk);
        while (cpu_waitrequest && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) chk("cpu_rd_timeout", 32'(waits), 32'd0);
        d = cpu_readdata;
        step();
        cpu_read = 1'b0;
    endtask

    initial begin
        int          w;
        int          cyc;
        logic        r0;
        logic [31:0] d;

        // Reset
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_ready", 32'(monitor_ready), 32'd1);
        chk("rst_error", 32'(monitor_error), 32'd0);
        chk("rst_readdata", cpu_readdata, 32'h0);
        chk("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
        step();

        // JTAG addressed read, latency and post-increment
        cpu_wr(8'h05, 32'hDEADBEEF, 4'hF, w);
        chk("cpu_wr_waits", 32'(w), 32'd0);
        cpu_wr(8'h06, 32'h66666666, 4'hF, w);
        jstrobe(0, jdo_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h05));
        wait_ready(cyc, r0);
        chk("t1_ready_low", 32'(r0), 32'd0);
        chk("t1_latency", 32'(cyc), 32'd3);
        chk("t1_MonDReg", MonDReg, 32'hDEADBEEF);
        jstrobe(1, '0);
        wait_ready(cyc, r0);
        chk("t1_jaddr_inc", MonDReg, 32'h66666666);

        // Streaming writes wrap DEPTH-1 -> 0
        jstrobe(0, jdo_a(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF));
        for (int k = 1; k <= 3; k++) begin
            jstrobe(2, jdo_b(32'(k)));
            wait_ready(cyc, r0);
        end
        cpu_rd(8'hFF, d, w);
        chk("t2_mem_ff", d, 32'd1);
        cpu_rd(8'h00, d, w);
        chk("t2_mem_00", d, 32'd2);
        cpu_rd(8'h01, d, w);
        chk("t2_mem_01", d, 32'd3);

        // CPU byte-enabled writes and read timing
        cpu_wr(8'h10, 32'hFFFFFFFF, 4'hF, w);
        cpu_wr(8'h10, 32'hA5A5A5A5, 4'b0011, w);
        cpu_rd(8'h10, d, w);
        chk("t3_be_low", d, 32'hFFFFA5A5);
        chk("t3_rd_waits", 32'(w), 32'd2);
        cpu_wr(8'h11, 32'h0, 4'hF, w);
        cpu_wr(8'h11, 32'h12345678, 4'b1100, w);
        cpu_rd(8'h11, d, w);
        chk("t3_be_high", d, 32'h12340000);

        // Overrun: two back-to-back streaming reads
        cpu_wr(8'h30, 32'h30303030, 4'hF, w);
        cpu_wr(8'h31, 32'h31313131, 4'hF, w);
        jstrobe(0, jdo_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h30));
        take_no_action_ocimem_a = 1'b1;
        step();
        step();
        take_no_action_ocimem_a = 1'b0;
        wait_ready(cyc, r0);
        @(negedge clk);
        chk("t4_error_set", 32'(monitor_error), 32'd1);
        chk("t4_MonDReg", MonDReg, 32'h30303030);
        step();
        jstrobe(1, '0);
        wait_ready(cyc, r0);
        chk("t4_one_read", MonDReg, 32'h31313131);
        chk("t4_error_sticky", 32'(monitor_error), 32'd1);
        jstrobe(0, jdo_a(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        @(negedge clk);
        chk("t4_error_clr", 32'(monitor_error), 32'd0);
        step();
        // Clear coinciding with an overrun: set wins
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        jstrobe(0, jdo_a(1'b0, 1'b1, 1'b1, 1'b0, 8'h00));
        wait_ready(cyc, r0);
        chk("t4_set_wins", 32'(monitor_error), 32'd1);
        jstrobe(0, jdo_a(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));

        // JTAG write pend beats a simultaneous CPU read
        jstrobe(0, jdo_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h40));
        jstrobe(2, jdo_b(32'hCAFE0001));
        cpu_rd(8'h40, d, w);
        chk("t5_post_write", d, 32'hCAFE0001);
        chk("t5_rd_waits", 32'(w), 32'd4);
        chk("t5_ready", 32'(monitor_ready), 32'd1);

        // CPU write protect
        cpu_wr(8'h20, 32'hAAAA0000, 4'hF, w);
        jstrobe(0, jdo_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        cpu_wr(8'h20, 32'h00001234, 4'hF, w);
        chk("t6_wr_waits", 32'(w), 32'd0);
        cpu_rd(8'h20, d, w);
`ifdef OCIMEM_CPU_WP_EN
        chk("t6_wp_mem", d, 32'hAAAA0000);
`else
        chk("t6_wp_mem", d, 32'h00001234);
`endif
        jstrobe(0, jdo_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

        // Reset during J_WR suppresses the write and clears jaddr
        cpu_wr(8'h50, 32'h50505050, 4'hF, w);
        jstrobe(0, jdo_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h50));
        jstrobe(2, jdo_b(32'hBADBAD00));
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t7_ready", 32'(monitor_ready), 32'd1);
        chk("t7_error", 32'(monitor_error), 32'd0);
        step();
        jstrobe(1, '0);
        wait_ready(cyc, r0);
        chk("t7_jaddr_rst", MonDReg, 32'd2);
        cpu_rd(8'h50, d, w);
        chk("t7_wr_suppressed", d, 32'h50505050);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
